// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: the display fetch always wins; two host ports share
// the remaining slots round-robin. Read data returns two cycles after the grant,
// routed by a tag that travels alongside the RAM read.
module vga_fb_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // scan-out fetch
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  // host 0
  input  logic              h0_valid,
  input  logic              h0_we,
  input  logic [ADDR_W-1:0] h0_addr,
  input  logic [DATA_W-1:0] h0_wdata,
  output logic              h0_ready,
  output logic              h0_rvalid,
  output logic [DATA_W-1:0] h0_rdata,
  // host 1
  input  logic              h1_valid,
  input  logic              h1_we,
  input  logic [ADDR_W-1:0] h1_addr,
  input  logic [DATA_W-1:0] h1_wdata,
  output logic              h1_ready,
  output logic              h1_rvalid,
  output logic [DATA_W-1:0] h1_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Read-return tags; the value minus one indexes the return channel.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_H0   = 2'd2;
  localparam logic [1:0] TAG_H1   = 2'd3;

  logic              gnt_disp, gnt_h0, gnt_h1;
  logic              rr_q, rr_d;            // 0: host 0 preferred on contention
  logic [1:0]        tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q [3];
  logic [DATA_W-1:0] rdata_d [3];
  logic [2:0]        rvalid_q, rvalid_d;

  // Grant selection: display first, then a lone host, then the round-robin pick.
  // Nothing is granted while in reset so no handshake completes then.
  always_comb begin
    gnt_disp = 1'b0;
    gnt_h0   = 1'b0;
    gnt_h1   = 1'b0;
    if (!rst) begin
      if (disp_req) begin
        gnt_disp = 1'b1;
      end else if (h0_valid && h1_valid) begin
        if (rr_q) gnt_h1 = 1'b1;
        else      gnt_h0 = 1'b1;
      end else if (h0_valid) begin
        gnt_h0 = 1'b1;
      end else if (h1_valid) begin
        gnt_h1 = 1'b1;
      end
    end
  end

  // RAM command and next state; address/data hold their last value when idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = TAG_NONE;
    rr_d    = rr_q;
    if (rst) begin
      addr_d  = '0;
      wdata_d = '0;
      rr_d    = 1'b0;
    end else if (gnt_disp) begin
      addr_d = disp_addr;
      tag_d  = TAG_DISP;
    end else if (gnt_h0) begin
      addr_d  = h0_addr;
      wdata_d = h0_wdata;
      tag_d   = h0_we ? TAG_NONE : TAG_H0;
      rr_d    = 1'b1;
    end else if (gnt_h1) begin
      addr_d  = h1_addr;
      wdata_d = h1_wdata;
      tag_d   = h1_we ? TAG_NONE : TAG_H1;
      rr_d    = 1'b0;
    end
  end

  assign mem_en    = gnt_disp | gnt_h0 | gnt_h1;
  assign mem_we    = (gnt_h0 & h0_we) | (gnt_h1 & h1_we);
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;
  assign h0_ready  = gnt_h0;
  assign h1_ready  = gnt_h1;

  // Return path: the tag of last cycle's read steers mem_rdata into one channel.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdata_d[i]  = rdata_q[i];
      rvalid_d[i] = 1'b0;
      if (!rst && tag_q == 2'(i + 1)) begin
        rdata_d[i]  = mem_rdata;
        rvalid_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= 1'b0;
      tag_q    <= TAG_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < 3; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  assign disp_rvalid = rvalid_q[TAG_DISP - 2'd1];
  assign h0_rvalid   = rvalid_q[TAG_H0 - 2'd1];
  assign h1_rvalid   = rvalid_q[TAG_H1 - 2'd1];
  assign disp_rdata  = rdata_q[0];
  assign h0_rdata    = rdata_q[1];
  assign h1_rdata    = rdata_q[2];

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one synchronous single-port framebuffer RAM between three requesters: the VGA scan-out fetch, which has absolute priority, and two host ports (CPU writer, blitter), which are arbitrated round-robin.
- Sits between the VGA timing/pixel pipeline and the framebuffer RAM.
- Returns read data to each requester with a fixed, tagged latency.

Parameters:
- ADDR_W, 16, framebuffer word address width.
- DATA_W, 32, framebuffer word width (4 pixels of 8-bit RGB332).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  scan-out read request; may be asserted in any cycle.
- disp_addr  in  ADDR_W  scan-out read address.
- disp_rvalid  out  1  scan-out read data valid.
- disp_rdata  out  DATA_W  scan-out read data.
- h0_valid  in  1  host 0 request.
- h0_we  in  1  host 0 write (1) / read (0).
- h0_addr  in  ADDR_W  host 0 address.
- h0_wdata  in  DATA_W  host 0 write data.
- h0_ready  out  1  host 0 request accepted this cycle.
- h0_rvalid  out  1  host 0 read data valid.
- h0_rdata  out  DATA_W  host 0 read data.
- h1_valid, h1_we, h1_addr, h1_wdata, h1_ready, h1_rvalid, h1_rdata: same as host 0, for host 1.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read with mem_en=1.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - All out strobes = 0: mem_en, mem_we, h*_ready, h*_rvalid, disp_rvalid.
  - All data/address outputs = 0.
  - RR pointer = host 0.
  - Tag pipeline cleared.
- Grant decision is combinational each cycle, evaluated in this order:
  1. disp_req=1: grant display. mem_en=1, mem_we=0, mem_addr=disp_addr. Both h*_ready=0.
  2. Else, if exactly one host is valid: grant that host.
  3. Else, if both hosts are valid: grant the host the RR pointer selects.
  4. Else: mem_en=0, with mem_addr/mem_wdata holding their last values.
- Host grant:
  - hN_ready=1, mem_en=1, mem_we=hN_we, mem_addr=hN_addr, mem_wdata=hN_wdata.
  - RR pointer updates at the clock edge to the other host.
  - The pointer does not change on display grants or idle cycles.
- Handshake: the transfer occurs when hN_valid & hN_ready. A host holds valid, we, addr and wdata stable until ready. The arbiter never drops an asserted request.
- Read return tags:
  - A read grant at cycle T pushes a 2-bit tag (none/disp/h0/h1) into stage 1.
  - At T+1, mem_rdata is captured into the requester's rdata register.
  - At T+2, the matching *_rvalid=1 for exactly one cycle. Fixed latency: 2 cycles from grant to rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline at one per cycle, and rvalids return in grant order.
- Non-selected rdata registers hold their previous value.
- Starvation bound: with disp_req low for at least 2 cycles in any window, each continuously-valid host is served within 2 free slots.
- Reset mid-operation: in-flight reads are discarded (no rvalid after rst), and pending handshakes are not accepted during rst.
- Same-address write then read from different requesters in consecutive cycles: the read returns the new data, per RAM write-before-read ordering. The arbiter adds no forwarding.

Test Plan:
- Reset: rst=1 for 3 cycles with all valids=1 -> mem_en=0, h0_ready=h1_ready=0, all rvalid=0; the first host grant after release goes to h0.
- Display priority: disp_req=1 with h0_valid=1 for 4 cycles -> mem_addr=disp_addr each cycle, h0_ready=0; when disp_req drops, h0_ready=1 in that same cycle.
- Round-robin: h0 and h1 both valid continuously, disp_req=0 -> grants alternate h0,h1,h0,h1; h1 is never granted twice in a row.
- Read latency and ordering: h0 read 0x0010 at T, disp read 0x0020 at T+1, with RAM preloaded 0xAABBCCDD/0x11223344 -> h0_rvalid at T+2 with 0xAABBCCDD, disp_rvalid at T+3 with 0x11223344.
- Write handshake under contention: h1 write 0x0005 <- 0xDEADBEEF while disp_req pulses 1,1,0 -> h1_ready only in the 3rd cycle; a later h0 read of 0x0005 returns 0xDEADBEEF.
- Reset mid-flight: h0 read granted at T, rst=1 at T+1 -> no h0_rvalid at T+2, and the RR pointer is back at h0.
